// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the direct-mapped write-back cache and the main-memory
// responder that serves its line fills and dirty-line writebacks.
//   - address split: BLK_W-bit block index = {TAG_W-bit tag, CI_W-bit index}
//   - block geometry: WORDS words of DATA_W bits, BO_W-bit word offset
//   - responder FSM state encoding
// -----------------------------------------------------------------------------
package cache_pkg;

   localparam int BLK_W  = 13;
   localparam int CI_W   = 10;
   localparam int TAG_W  = 3;
   localparam int WORDS  = 16;
   localparam int BO_W   = 4;
   localparam int DATA_W = 32;

   typedef logic [BLK_W-1:0] blk_idx_t;
   typedef logic [BO_W-1:0]  word_off_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAT_WAIT,
      ST_RD_BURST,
      ST_WR_BURST,
      ST_WR_DONE
   } resp_state_e;

endpackage : cache_pkg

// File: rtl/mem_block_array.sv
// -----------------------------------------------------------------------------
// mem_block_array
// Block-organised main-memory storage: 2**BLK_W blocks of WORDS x DATA_W.
// Ports:
//   clk                      write clock (rising edge)
//   rd_blk, rd_word -> rd_data   asynchronous read port
//   we, wr_blk, wr_word, wr_data synchronous write port
// Every block starts out with word j holding the value j.
// -----------------------------------------------------------------------------
module mem_block_array
   import cache_pkg::*;
#(
   parameter int BLK_W_P  = BLK_W,
   parameter int WORDS_P  = WORDS,
   parameter int DATA_W_P = DATA_W,
   localparam int BO_W_P  = $clog2(WORDS_P)
) (
   input  logic                clk,
   input  logic [BLK_W_P-1:0]  rd_blk,
   input  logic [BO_W_P-1:0]   rd_word,
   output logic [DATA_W_P-1:0] rd_data,
   input  logic                we,
   input  logic [BLK_W_P-1:0]  wr_blk,
   input  logic [BO_W_P-1:0]   wr_word,
   input  logic [DATA_W_P-1:0] wr_data
);

   typedef logic [WORDS_P-1:0][DATA_W_P-1:0] block_t;

   function automatic block_t init_block();
      block_t b;
      for (int j = 0; j < WORDS_P; j++) begin
         b[j] = DATA_W_P'(j);
      end
      return b;
   endfunction

   localparam block_t INIT_BLK = init_block();

   // Power-up contents come from the declaration initialiser, which maps to
   // RAM initialisation in an FPGA flow.
   block_t mem [2**BLK_W_P] = '{default: INIT_BLK};

   assign rd_data = mem[rd_blk][rd_word];

   // NOTE: the storage has no reset branch; contents must survive rst, and a
   // reset on a RAM array would also prevent it mapping onto block memory.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_blk][wr_word] <= wr_data;
      end
   end

endmodule : mem_block_array

// File: rtl/main_memory_responder.sv
// -----------------------------------------------------------------------------
// main_memory_responder
// Main-memory side of the cache line-transfer interface. Accepts one block
// request at a time; a read streams WORDS beats back after LATENCY idle
// cycles, a write absorbs WORDS beats and then pulses wr_done.
// Ports:
//   clk, rst                          clock, async active-high reset
//   req_valid/req_ready               request handshake
//   req_write, req_block              request kind and block index
//   rdata/rdata_valid/rdata_last      read beat stream (registered-state only)
//   rdata_ready                       cache accepts read beat
//   wdata/wdata_valid/wdata_ready     write beat stream
//   wr_done                           one-cycle writeback-committed pulse
// -----------------------------------------------------------------------------
module main_memory_responder
   import cache_pkg::*;
#(
   parameter int BLK_W_P  = BLK_W,
   parameter int WORDS_P  = WORDS,
   parameter int DATA_W_P = DATA_W,
   parameter int LATENCY  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [BLK_W_P-1:0]  req_block,
   output logic [DATA_W_P-1:0] rdata,
   output logic                rdata_valid,
   output logic                rdata_last,
   input  logic                rdata_ready,
   input  logic [DATA_W_P-1:0] wdata,
   input  logic                wdata_valid,
   output logic                wdata_ready,
   output logic                wr_done
);

   localparam int BO_W_P = $clog2(WORDS_P);
   // A zero-latency build still needs a legal (1-bit) counter declaration.
   localparam int LAT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
   localparam logic [BO_W_P-1:0] LAST_BEAT = BO_W_P'(WORDS_P - 1);

   resp_state_e          state_q, state_d;
   logic [BO_W_P-1:0]    beat_q,  beat_d;
   logic [LAT_W-1:0]     lat_q,   lat_d;
   logic [BLK_W_P-1:0]   blk_q,   blk_d;
   logic                 mem_we;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         lat_q   <= '0;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         lat_q   <= lat_d;
         blk_q   <= blk_d;
      end
   end

   // NOTE: every output of this block is given a default first, so no path
   // through the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      lat_d       = lat_q;
      blk_d       = blk_q;
      mem_we      = 1'b0;
      req_ready   = 1'b0;
      rdata_valid = 1'b0;
      rdata_last  = 1'b0;
      wdata_ready = 1'b0;
      wr_done     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               blk_d  = req_block;
               beat_d = '0;
               if (req_write) begin
                  state_d = ST_WR_BURST;
               end else if (LATENCY == 0) begin
                  state_d = ST_RD_BURST;
               end else begin
                  // Loaded with LATENCY-1 because the edge that sees zero
                  // is itself the last idle edge before the first beat.
                  state_d = ST_LAT_WAIT;
                  lat_d   = LAT_W'(LATENCY - 1);
               end
            end
         end

         ST_LAT_WAIT: begin
            if (lat_q == '0) begin
               state_d = ST_RD_BURST;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end

         ST_RD_BURST: begin
            rdata_valid = 1'b1;
            rdata_last  = (beat_q == LAST_BEAT);
            if (rdata_ready) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_WR_BURST: begin
            wdata_ready = 1'b1;
            if (wdata_valid) begin
               mem_we = 1'b1;
               beat_d = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) begin
                  state_d = ST_WR_DONE;
               end
            end
         end

         ST_WR_DONE: begin
            wr_done = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Read port indexed only by registered block/beat, so rdata has no
   // combinational path from any input.
   mem_block_array #(
      .BLK_W_P  (BLK_W_P),
      .WORDS_P  (WORDS_P),
      .DATA_W_P (DATA_W_P)
   ) u_mem (
      .clk     (clk),
      .rd_blk  (blk_q),
      .rd_word (beat_q),
      .rd_data (rdata),
      .we      (mem_we),
      .wr_blk  (blk_q),
      .wr_word (beat_q),
      .wr_data (wdata)
   );

endmodule : main_memory_responder

// File: tb/tb_main_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_main_memory_responder
// Self-checking bench for main_memory_responder. A LATENCY=4 instance covers
// reads, writes, stalls, gaps and reset; a LATENCY=0 instance covers the
// back-to-back request case. Expected read data comes from a sparse word
// model: any word never written holds its own word index.
// -----------------------------------------------------------------------------
module tb_main_memory_responder;

   logic        clk = 1'b0;
   logic        rst;

   // LATENCY = 4 instance
   logic        req_valid, req_ready, req_write;
   logic [12:0] req_block;
   logic [31:0] rdata, wdata;
   logic        rdata_valid, rdata_last, rdata_ready;
   logic        wdata_valid, wdata_ready, wr_done;

   // LATENCY = 0 instance
   logic        req_valid0, req_ready0, req_write0;
   logic [12:0] req_block0;
   logic [31:0] rdata0, wdata0;
   logic        rdata_valid0, rdata_last0, rdata_ready0;
   logic        wdata_valid0, wdata_ready0, wr_done0;

   int checks = 0;
   int errors = 0;

   // Sparse memory model keyed by block*16 + word.
   logic [31:0] model_mem [int];

   always #5 clk = ~clk;

   main_memory_responder #(.LATENCY(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_block(req_block),
      .rdata(rdata), .rdata_valid(rdata_valid), .rdata_last(rdata_last),
      .rdata_ready(rdata_ready),
      .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
      .wr_done(wr_done)
   );

   main_memory_responder #(.LATENCY(0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
      .req_block(req_block0),
      .rdata(rdata0), .rdata_valid(rdata_valid0), .rdata_last(rdata_last0),
      .rdata_ready(rdata_ready0),
      .wdata(wdata0), .wdata_valid(wdata_valid0), .wdata_ready(wdata_ready0),
      .wr_done(wr_done0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input logic [12:0] blk, input int w);
      int key = int'(blk) * 16 + w;
      return model_mem.exists(key) ? model_mem[key] : 32'(w);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read a block from the LATENCY=4 instance; optionally stall at one beat.
   task automatic read_block(input logic [12:0] blk, input int stall_beat,
                             input int stall_cycles);
      int n;
      rdata_ready = 1'b1;
      req_valid   = 1'b1;
      req_write   = 1'b0;
      req_block   = blk;
      chk("rd_req_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      chk("rd_busy_req_ready", 32'(req_ready), 32'd0);
      n = 0;
      while (!rdata_valid && n < 50) begin
         tick();
         n++;
      end
      chk("rd_latency", 32'(n), 32'd4);
      for (int b = 0; b < 16; b++) begin
         n = 0;
         while (!rdata_valid && n < 50) begin
            tick();
            n++;
         end
         chk("rd_valid", 32'(rdata_valid), 32'd1);
         chk("rd_data", rdata, exp_word(blk, b));
         chk("rd_last", 32'(rdata_last), 32'(b == 15));
         if (b == stall_beat) begin
            rdata_ready = 1'b0;
            for (int s = 0; s < stall_cycles; s++) begin
               tick();
               chk("rd_hold_valid", 32'(rdata_valid), 32'd1);
               chk("rd_hold_data", rdata, exp_word(blk, b));
            end
            rdata_ready = 1'b1;
         end
         tick();
      end
      chk("rd_end_valid", 32'(rdata_valid), 32'd0);
      chk("rd_end_req_ready", 32'(req_ready), 32'd1);
   endtask

   // Write a block on the LATENCY=4 instance. gap_mode: 0 none, 1 alternate,
   // 2 random. abort_after < 16 asserts rst once that many beats are written.
   task automatic write_block(input logic [12:0] blk, input logic [31:0] d [16],
                              input int gap_mode, input int abort_after);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_block = blk;
      chk("wr_req_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (k == abort_after) begin
            wdata_valid = 1'b0;
            rst = 1'b1;
            #1;
            chk("rst_req_ready", 32'(req_ready), 32'd1);
            chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
            chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);
            chk("rst_wr_done", 32'(wr_done), 32'd0);
            tick();
            rst = 1'b0;
            return;
         end
         if ((gap_mode == 1 && k % 2 == 1) || (gap_mode == 2 && $urandom_range(1) == 1)) begin
            wdata_valid = 1'b0;
            wdata = $urandom;
            tick();
            chk("wr_gap_ready", 32'(wdata_ready), 32'd1);
         end
         wdata = d[k];
         wdata_valid = 1'b1;
         chk("wr_ready", 32'(wdata_ready), 32'd1);
         tick();
         model_mem[int'(blk) * 16 + k] = d[k];
         if (k < 15) chk("wr_done_early", 32'(wr_done), 32'd0);
      end
      wdata_valid = 1'b0;
      chk("wr_done_pulse", 32'(wr_done), 32'd1);
      tick();
      chk("wr_done_clear", 32'(wr_done), 32'd0);
      chk("wr_end_req_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] d [16];
      logic [12:0] rblk;

      rst = 1'b1;
      req_valid = 0; req_write = 0; req_block = '0; rdata_ready = 1;
      wdata = '0; wdata_valid = 0;
      req_valid0 = 0; req_write0 = 0; req_block0 = '0; rdata_ready0 = 1;
      wdata0 = '0; wdata_valid0 = 0;

      // Reset state.
      #1;
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_rdata_valid", 32'(rdata_valid), 32'd0);
      chk("reset_rdata_last", 32'(rdata_last), 32'd0);
      chk("reset_wdata_ready", 32'(wdata_ready), 32'd0);
      chk("reset_wr_done", 32'(wr_done), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // 1: plain read of an untouched block.
      read_block(13'd5, -1, 0);

      // Stray beat signals while idle must not write or advance anything.
      wdata_valid = 1'b1;
      wdata = 32'hDEAD_BEEF;
      rdata_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("idle_wdata_ready", 32'(wdata_ready), 32'd0);
         tick();
      end
      wdata_valid = 1'b0;

      // 2: writeback then readback; neighbour block unaffected.
      for (int k = 0; k < 16; k++) d[k] = 32'hA0 + 32'(k);
      write_block(13'h1ABC, d, 0, 16);
      read_block(13'h1ABC, -1, 0);
      read_block(13'h1ABB, -1, 0);

      // 3: three-cycle consumer stall at beat 7.
      read_block(13'd5, 7, 3);

      // 4: alternate-cycle write gaps.
      for (int k = 0; k < 16; k++) d[k] = $urandom;
      write_block(13'd300, d, 1, 16);
      read_block(13'd300, -1, 0);

      // 5: reset after six write beats to block 2.
      for (int k = 0; k < 16; k++) d[k] = $urandom;
      write_block(13'd2, d, 0, 6);
      tick();
      read_block(13'd2, -1, 0);

      // Randomised write/read pairs with random gaps and stalls.
      for (int t = 0; t < 3; t++) begin
         rblk = 13'($urandom);
         for (int k = 0; k < 16; k++) d[k] = $urandom;
         write_block(rblk, d, 2, 16);
         read_block(rblk, int'($urandom_range(15)), int'($urandom_range(1, 3)));
      end

      // 6: LATENCY=0 with req_valid held high across the burst.
      req_valid0 = 1'b1;
      req_write0 = 1'b0;
      req_block0 = 13'd7;
      chk("l0_req_ready", 32'(req_ready0), 32'd1);
      tick();
      for (int b = 0; b < 16; b++) begin
         chk("l0_valid", 32'(rdata_valid0), 32'd1);
         chk("l0_data", rdata0, 32'(b));
         chk("l0_no_accept", 32'(req_ready0), 32'd0);
         tick();
      end
      chk("l0_idle_req_ready", 32'(req_ready0), 32'd1);
      chk("l0_idle_valid", 32'(rdata_valid0), 32'd0);
      req_block0 = 13'd9;
      tick();
      chk("l0_second_valid", 32'(rdata_valid0), 32'd1);
      chk("l0_second_data", rdata0, 32'd0);
      req_valid0 = 1'b0;
      tick();
      chk("l0_second_beat1", rdata0, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_main_memory_responder
